// File: rtl/reg_op_sequencer_pkg.sv
// Purpose: opcode and FSM-state encodings shared by the register-op sequencer and its bench.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package reg_op_sequencer_pkg;

  // Opcodes, captured with start
  localparam logic [2:0] OP_MOV    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_AND    = 3'd3;
  localparam logic [2:0] OP_OR     = 3'd4;
  localparam logic [2:0] OP_LDI    = 3'd5;
  localparam logic [2:0] OP_MUL    = 3'd6;
  localparam logic [2:0] OP_CLRALL = 3'd7;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_CLR   = 3'd4;

  // True for the only opcode whose EXEC phase is longer than one cycle
  function automatic logic op_is_multicycle(input logic [2:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/reg_op_sequencer_shift_add_mul.sv
// Purpose: iterative unsigned shift-add multiplier, one multiplier bit consumed per cycle.
// Latency: DATA_W cycles after the start edge; valid marks the cycle whose product output is final.
// Backpressure: none; a new start simply restarts the operation, reset aborts it.
module shift_add_mul #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  valid
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] step_sum;

  // One shift-add step per cycle while iterations remain; start reloads the operands
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  // The final step's sum is presented directly so the caller can capture it in the same cycle
  assign product = step_sum;
  assign valid   = (cnt_q == CNT_W'(1));

  // Iteration state; reset leaves the multiplier idle
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Purpose: command-driven initiator that reads two registers, computes, and writes one back (or clears the file).
// Latency: 3 cycles busy for simple ops, DATA_W+2 for MUL, NREGS for CLRALL; write in the last busy cycle.
// Backpressure: start is only honoured in IDLE; a start while busy is dropped, never queued.
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] a_sel,
  input  logic [ADDR_W-1:0] b_sel,
  input  logic [ADDR_W-1:0] d_sel,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output logic              carry,
  output logic [ADDR_W-1:0] rf_srcA,
  output logic [ADDR_W-1:0] rf_srcB,
  input  logic [DATA_W-1:0] rf_dataA,
  input  logic [DATA_W-1:0] rf_dataB,
  output logic [ADDR_W-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_dataD,
  output logic              rf_ld
);

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] a_sel_q, a_sel_d;
  logic [ADDR_W-1:0] b_sel_q, b_sel_d;
  logic [ADDR_W-1:0] d_sel_q, d_sel_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              res_c_q, res_c_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [DATA_W:0]     alu_sum;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                mul_start;
  logic [2*DATA_W-1:0] mul_product;
  logic                mul_valid;
  logic                clr_last;

  // The multiplier is loaded straight from the read ports at the end of FETCH,
  // so its DATA_W iterations line up exactly with the EXEC cycles.
  assign mul_start = (state_q == ST_FETCH) && op_is_multicycle(op_q);
  assign clr_last  = (clr_cnt_q == ADDR_W'(NREGS - 1));

  shift_add_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (rf_dataA),
    .b       (rf_dataB),
    .product (mul_product),
    .valid   (mul_valid)
  );

  // Single-cycle ALU on the operands captured in FETCH
  always_comb begin
    alu_sum = {1'b0, opa_q} + {1'b0, opb_q};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_MOV: alu_res = opa_q;
      OP_ADD: begin
        alu_res = alu_sum[DATA_W-1:0];
        alu_c   = alu_sum[DATA_W];
      end
      OP_SUB: begin
        alu_res = opa_q - opb_q;
        alu_c   = (opa_q < opb_q);
      end
      OP_AND: alu_res = opa_q & opb_q;
      OP_OR:  alu_res = opa_q | opb_q;
      OP_LDI: alu_res = imm_q;
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Next-state and datapath register updates for the command FSM
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_sel_d   = a_sel_q;
    b_sel_d   = b_sel_q;
    d_sel_d   = d_sel_q;
    imm_d     = imm_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    res_c_d   = res_c_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_sel_d = a_sel;
          b_sel_d = b_sel;
          d_sel_d = d_sel;
          imm_d   = imm;
          if (op == OP_CLRALL) begin
            clr_cnt_d = '0;
            state_d   = ST_CLR;
          end else begin
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        opa_d   = rf_dataA;
        opb_d   = rf_dataB;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_is_multicycle(op_q)) begin
          if (mul_valid) begin
            res_d   = mul_product[DATA_W-1:0];
            res_c_d = |mul_product[2*DATA_W-1:DATA_W];
            state_d = ST_WRITE;
          end
        end else begin
          res_d   = alu_res;
          res_c_d = alu_c;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        zero_d  = (res_q == '0);
        carry_d = res_c_q;
        state_d = ST_IDLE;
      end
      ST_CLR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_last) begin
          zero_d  = 1'b1;
          carry_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so rf_ld/done carry no input paths
  always_comb begin
    busy     = (state_q != ST_IDLE);
    rf_ld    = (state_q == ST_WRITE) || (state_q == ST_CLR);
    done     = (state_q == ST_WRITE) || ((state_q == ST_CLR) && clr_last);
    rf_srcA  = a_sel_q;
    rf_srcB  = b_sel_q;
    rf_dest  = '0;
    rf_dataD = '0;
    if (state_q == ST_WRITE) begin
      rf_dest  = d_sel_q;
      rf_dataD = res_q;
    end else if (state_q == ST_CLR) begin
      rf_dest  = clr_cnt_q;
    end
    zero     = zero_q;
    carry    = carry_q;
  end

  // State registers; reset aborts any command in flight at the reset edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      d_sel_q   <= '0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      res_c_q   <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_sel_q   <= a_sel_d;
      b_sel_q   <= b_sel_d;
      d_sel_q   <= d_sel_d;
      imm_q     <= imm_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      res_c_q   <= res_c_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Purpose: directed self-checking bench for reg_op_sequencer with a behavioural 8x8 register file.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_op_sequencer;
  import reg_op_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [2:0] a_sel, b_sel, d_sel;
  logic [7:0] imm;
  logic       busy, done, zero, carry;
  logic [2:0] rf_srcA, rf_srcB, rf_dest;
  logic [7:0] rf_dataA, rf_dataB, rf_dataD;
  logic       rf_ld;

  logic [7:0] rf_mem [8];

  int n_tests = 0;
  int n_fail  = 0;

  int nbusy, ld_first, nld, ndone;
  bit dest_ok;
  int ld_seen;

  reg_op_sequencer #(.DATA_W(8), .ADDR_W(3), .NREGS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .d_sel    (d_sel),
    .imm      (imm),
    .busy     (busy),
    .done     (done),
    .zero     (zero),
    .carry    (carry),
    .rf_srcA  (rf_srcA),
    .rf_srcB  (rf_srcB),
    .rf_dataA (rf_dataA),
    .rf_dataB (rf_dataB),
    .rf_dest  (rf_dest),
    .rf_dataD (rf_dataD),
    .rf_ld    (rf_ld)
  );

  always #5 clk = ~clk;

  // Register file: combinational reads, write on posedge when ld
  always @(posedge clk) begin
    if (rf_ld) rf_mem[rf_dest] <= rf_dataD;
  end
  assign rf_dataA = rf_mem[rf_srcA];
  assign rf_dataB = rf_mem[rf_srcB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and watch it until busy drops (bounded). inj_at>0 pulses an
  // ADD start for two cycles starting at that busy cycle, while the command is running.
  task automatic run_cmd(input logic [2:0] op_i, input logic [2:0] a_i, input logic [2:0] b_i,
                         input logic [2:0] d_i, input logic [7:0] imm_i, input int inj_at,
                         output int o_busy, output int o_ld_first, output int o_nld,
                         output int o_ndone, output bit o_dest_ok);
    logic [2:0] exp_dest;
    o_busy = 0; o_ld_first = 0; o_nld = 0; o_ndone = 0; o_dest_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = op_i; a_sel = a_i; b_sel = b_i; d_sel = d_i; imm = imm_i;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (inj_at > 0 && k == inj_at) begin
        start = 1'b1; op = OP_ADD; a_sel = 3'd1; b_sel = 3'd1; d_sel = 3'd3; imm = 8'h00;
      end
      if (inj_at > 0 && k == inj_at + 2) start = 1'b0;
      if (!busy) break;
      o_busy++;
      if (rf_ld) begin
        exp_dest = (op_i == OP_CLRALL) ? o_nld[2:0] : d_i;
        if (rf_dest !== exp_dest) o_dest_ok = 1'b0;
        if (o_nld == 0) o_ld_first = k;
        o_nld++;
      end
      if (done) o_ndone++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a_sel = 3'd0; b_sel = 3'd0; d_sel = 3'd0; imm = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ld", rf_ld, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_dest", rf_dest, 0);
    chk("rst_dataD", rf_dataD, 0);
    chk("rst_srcA", rf_srcA, 0);
    chk("rst_srcB", rf_srcB, 0);
    reset = 1'b0;

    // 1. LDI d=3 imm=5A
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd3, 8'h5A, 0, nbusy, ld_first, nld, ndone, dest_ok);
    chk("ldi_busy", nbusy, 3);
    chk("ldi_ld_cycle", ld_first, 3);
    chk("ldi_nld", nld, 1);
    chk("ldi_done", ndone, 1);
    chk("ldi_dest", dest_ok, 1);
    chk("ldi_r3", rf_mem[3], 8'h5A);
    chk("ldi_zero", zero, 0);
    chk("ldi_carry", carry, 0);

    // 2. ADD F0+20 and SUB r1-r1
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd1, 8'hF0, 0, nbusy, ld_first, nld, ndone, dest_ok);
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd2, 8'h20, 0, nbusy, ld_first, nld, ndone, dest_ok);
    run_cmd(OP_ADD, 3'd1, 3'd2, 3'd4, 8'h00, 0, nbusy, ld_first, nld, ndone, dest_ok);
    chk("add_r4", rf_mem[4], 8'h10);
    chk("add_carry", carry, 1);
    chk("add_zero", zero, 0);
    chk("add_busy", nbusy, 3);
    run_cmd(OP_SUB, 3'd1, 3'd1, 3'd5, 8'h00, 0, nbusy, ld_first, nld, ndone, dest_ok);
    chk("sub0_r5", rf_mem[5], 8'h00);
    chk("sub0_zero", zero, 1);
    chk("sub0_carry", carry, 0);

    // 3. SUB with borrow, MUL 12*0F
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd6, 8'h10, 0, nbusy, ld_first, nld, ndone, dest_ok);
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd7, 8'h20, 0, nbusy, ld_first, nld, ndone, dest_ok);
    run_cmd(OP_SUB, 3'd6, 3'd7, 3'd0, 8'h00, 0, nbusy, ld_first, nld, ndone, dest_ok);
    chk("subb_r0", rf_mem[0], 8'hF0);
    chk("subb_carry", carry, 1);
    chk("subb_zero", zero, 0);
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd6, 8'h12, 0, nbusy, ld_first, nld, ndone, dest_ok);
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd7, 8'h0F, 0, nbusy, ld_first, nld, ndone, dest_ok);
    run_cmd(OP_SUB, 3'd7, 3'd6, 3'd5, 8'h00, 0, nbusy, ld_first, nld, ndone, dest_ok);
    chk("subb2_r5", rf_mem[5], 8'hFD);
    run_cmd(OP_MUL, 3'd6, 3'd7, 3'd1, 8'h00, 0, nbusy, ld_first, nld, ndone, dest_ok);
    chk("mul_r1", rf_mem[1], 8'h0E);
    chk("mul_carry", carry, 1);
    chk("mul_zero", zero, 0);
    chk("mul_busy", nbusy, 10);
    chk("mul_ld_cycle", ld_first, 10);
    chk("mul_done", ndone, 1);

    // 4. start ADD during MUL is ignored
    run_cmd(OP_MUL, 3'd6, 3'd7, 3'd2, 8'h00, 3, nbusy, ld_first, nld, ndone, dest_ok);
    chk("inj_r2", rf_mem[2], 8'h0E);
    chk("inj_r3_untouched", rf_mem[3], 8'h5A);
    chk("inj_nld", nld, 1);
    chk("inj_done", ndone, 1);
    chk("inj_dest", dest_ok, 1);
    chk("inj_busy", nbusy, 10);

    // 5. CLRALL after filling every register with nonzero values
    for (int i = 0; i < 8; i++) begin
      run_cmd(OP_LDI, 3'd0, 3'd0, 3'(i), 8'(i) + 8'h11, 0, nbusy, ld_first, nld, ndone, dest_ok);
    end
    chk("fill_r7", rf_mem[7], 8'h18);
    run_cmd(OP_CLRALL, 3'd0, 3'd0, 3'd0, 8'h00, 0, nbusy, ld_first, nld, ndone, dest_ok);
    chk("clr_nld", nld, 8);
    chk("clr_ld_first", ld_first, 1);
    chk("clr_busy", nbusy, 8);
    chk("clr_dest_seq", dest_ok, 1);
    chk("clr_done", ndone, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr_r%0d", i), rf_mem[i], 8'h00);
    end
    chk("clr_zero", zero, 1);
    chk("clr_carry", carry, 0);

    // 6. reset during MUL EXEC
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd3, 8'h03, 0, nbusy, ld_first, nld, ndone, dest_ok);
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd4, 8'h04, 0, nbusy, ld_first, nld, ndone, dest_ok);
    ld_seen = 0;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a_sel = 3'd3; b_sel = 3'd4; d_sel = 3'd1; imm = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (rf_ld) ld_seen++;
      if (k < 4) @(negedge clk);
    end
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ld", rf_ld, 0);
    chk("abort_done", done, 0);
    chk("abort_zero", zero, 0);
    chk("abort_carry", carry, 0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rf_ld) ld_seen++;
    end
    chk("abort_no_ld", ld_seen, 0);
    chk("abort_r1", rf_mem[1], 8'h00);
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd5, 8'h77, 0, nbusy, ld_first, nld, ndone, dest_ok);
    chk("post_ldi_busy", nbusy, 3);
    chk("post_ldi_r5", rf_mem[5], 8'h77);
    chk("post_ldi_done", ndone, 1);
    chk("post_ldi_zero", zero, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
